// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU main control FSM: sequences fetch/decode/execute/memory/write-back.
// Define MULTI_CYCLE_CTRL_ADDI_EN to enable the addi path (ADDIEX/ADDIWB states).
module multi_cycle_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b011;

    // The control path is width-independent; only reject nonsense widths.
    if (WIDTH < 1) begin : g_width_check
        $error("multi_cycle_ctrl: WIDTH must be positive");
    end

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
        S_ADDIEX,
        S_ADDIWB,
`endif
        S_JUMP
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   illegal_set;
    logic   pc_write;
    logic   pc_write_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        illegal_set   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_ctrl      = ALU_ADD;

        unique case (state_q)
            S_RST: begin
                alu_ctrl = 3'b000;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        illegal_set = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB;
                case (funct)
                    FN_ADD: alu_ctrl = ALU_ADD;
                    FN_SUB: alu_ctrl = ALU_SUB;
                    FN_AND: alu_ctrl = ALU_AND;
                    FN_OR:  alu_ctrl = ALU_OR;
                    FN_SLT: alu_ctrl = ALU_SLT;
                    default: begin
                        illegal_set = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctrl      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: state_d = S_RST;
        endcase

        pc_en = pc_write | (pc_write_cond & zero);
    end

    assign illegal_d = illegal_q | illegal_set;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: random instruction stream vs per-instruction
// summaries predicted from the instruction set rules (honours MULTI_CYCLE_CTRL_ADDI_EN).
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_ctrl;

    multi_cycle_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_ctrl(alu_ctrl), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cycles;
        int         irw;
        int         rw;
        int         m2r;
        int         rdst;
        int         mrd;
        int         mwr;
        int         pcen;
        logic [1:0] pcsrc;
        logic [2:0] exalu;
        int         immadd;
        logic       ill;
        logic       fok;
    } summ_t;

    summ_t exp_q[$];
    summ_t obs;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  model_ill = 1'b0;
    logic  in_ins = 1'b0;
    logic  prev_f = 1'b0;
    logic  is_f;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected summary from the instruction's architectural behaviour.
    function automatic summ_t model(input logic [5:0] op, input logic [5:0] fn,
                                    input logic z, input int f, input int m,
                                    input logic ill_in);
        summ_t e;
        logic ok;
        logic [2:0] fa;
        e.cycles = f + 2; e.irw = 1; e.rw = 0; e.m2r = 0; e.rdst = 0;
        e.mrd = 0; e.mwr = 0; e.pcen = 0; e.pcsrc = 2'b00; e.exalu = 3'b111;
        e.immadd = 0; e.ill = ill_in; e.fok = 1'b1;
        ok = 1'b1;
        case (fn)
            6'b100000: fa = 3'b100;
            6'b100010: fa = 3'b110;
            6'b100100: fa = 3'b000;
            6'b100101: fa = 3'b001;
            6'b101010: fa = 3'b011;
            default: begin fa = 3'b100; ok = 1'b0; end
        endcase
        case (op)
            OP_LW: begin
                e.cycles = f + 5 + m; e.rw = 1; e.m2r = 1;
                e.mrd = 1 + m; e.immadd = 1;
            end
            OP_SW: begin
                e.cycles = f + 4 + m; e.mwr = 1 + m; e.immadd = 1;
            end
            OP_R: begin
                e.exalu = fa;
                if (ok) begin
                    e.cycles = f + 4; e.rw = 1; e.rdst = 1;
                end else begin
                    e.cycles = f + 3; e.ill = 1'b1;
                end
            end
            OP_BEQ: begin
                e.cycles = f + 3; e.exalu = 3'b110;
                if (z) begin e.pcen = 1; e.pcsrc = 2'b01; end
            end
            OP_J: begin
                e.cycles = f + 3; e.pcen = 1; e.pcsrc = 2'b10;
            end
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
            OP_ADDI: begin
                e.cycles = f + 4; e.rw = 1; e.immadd = 1;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Drives one instruction; f = fetch stall cycles, m = memory stall cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int f, input int m);
        summ_t e;
        int    st;
        e = model(op, fn, z, f, m, model_ill);
        model_ill = e.ill;
        exp_q.push_back(e);
        opcode = op;
        funct  = fn;
        zero   = z;
        st = (op == OP_LW || op == OP_SW) ? f + 3 : -1;
        for (int k = 0; k < e.cycles; k++) begin
            mem_ready = !((k < f) || (st >= 0 && k >= st && k < st + m));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        mem_ready = 1'b0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic run_random(input int n);
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0: op = OP_LW;
                1: op = OP_SW;
                2, 3: op = OP_R;
                4: op = OP_BEQ;
                5: op = OP_J;
                6: op = OP_ADDI;
                default: op = 6'($urandom);
            endcase
            if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
            else fn = fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    function automatic int outs_vec();
        return int'({pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
                     alu_ctrl, illegal});
    endfunction

    task automatic close_instr();
        summ_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_instr", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("cycles", obs.cycles, e.cycles);
            chk("ir_write_cnt", obs.irw, e.irw);
            chk("reg_write_cnt", obs.rw, e.rw);
            chk("mem_to_reg_wr", obs.m2r, e.m2r);
            chk("reg_dst_wr", obs.rdst, e.rdst);
            chk("mem_read_iord_cnt", obs.mrd, e.mrd);
            chk("mem_write_cnt", obs.mwr, e.mwr);
            chk("pc_en_cnt", obs.pcen, e.pcen);
            chk("pc_source", int'(obs.pcsrc), int'(e.pcsrc));
            chk("exec_alu_ctrl", int'(obs.exalu), int'(e.exalu));
            chk("imm_add_cnt", obs.immadd, e.immadd);
            chk("illegal", int'(illegal), int'(e.ill));
            chk("fetch_outs", int'(obs.fok), int'(e.fok));
        end
    endtask

    // Monitor: an instruction starts at the first fetch cycle after a non-fetch cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_ins = 1'b0;
            prev_f = 1'b0;
        end else begin
            is_f = mem_read && !iord;
            if (is_f && !prev_f) begin
                if (in_ins) close_instr();
                in_ins = 1'b1;
                obs.cycles = 0; obs.irw = 0; obs.rw = 0; obs.m2r = 0;
                obs.rdst = 0; obs.mrd = 0; obs.mwr = 0; obs.pcen = 0;
                obs.pcsrc = 2'b00; obs.exalu = 3'b111; obs.immadd = 0;
                obs.ill = 1'b0; obs.fok = 1'b1;
            end
            if (in_ins) begin
                obs.cycles++;
                if (ir_write) begin
                    obs.irw++;
                    if (!(pc_en && mem_read && alu_ctrl == 3'b100 &&
                          alu_src_b == 2'b01 && !alu_src_a && pc_source == 2'b00))
                        obs.fok = 1'b0;
                end
                if (reg_write) begin
                    obs.rw++;
                    if (mem_to_reg) obs.m2r++;
                    if (reg_dst) obs.rdst++;
                end
                if (mem_read && iord) obs.mrd++;
                if (mem_write) obs.mwr++;
                if (pc_en && !ir_write) begin
                    obs.pcen++;
                    obs.pcsrc = pc_source;
                end
                if (alu_src_a && alu_src_b == 2'b00) obs.exalu = alu_ctrl;
                if (alu_src_a && alu_src_b == 2'b10) obs.immadd++;
            end
            prev_f = is_f;
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs_vec(), 0);
        rst_n = 1'b1;
        chk("rst_state_outs", outs_vec(), 0);
        @(posedge clk);
        #1;
        // Directed cases first, then random traffic.
        run_instr(OP_R, 6'b100010, 1'b0, 0, 0);
        run_instr(OP_R, 6'b101010, 1'b0, 0, 0);
        run_instr(OP_LW, 6'b000000, 1'b0, 0, 2);
        run_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0);
        run_instr(OP_BEQ, 6'b000000, 1'b0, 1, 0);
        run_instr(OP_ADDI, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b111111, 6'b100000, 1'b0, 0, 0);
        run_instr(OP_R, 6'b000111, 1'b0, 0, 0);
        run_instr(OP_SW, 6'b000000, 1'b0, 2, 1);
        run_instr(OP_J, 6'b000000, 1'b0, 0, 0);
        run_random(60);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        drain();

        // Reset in the middle of a stalled lw read.
        chk("illegal_before_rst", int'(illegal), 1);
        opcode = OP_LW;
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        chk("memrd_strobes", int'({mem_read, iord}), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outs", outs_vec(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ill = 1'b0;
        @(posedge clk);
        #1;
        run_random(20);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
